// File: rtl/issue_dispatcher.sv
// One-entry dispatch slot between the fetcher and the ROB/RS/LSB issue ports.
// Optional build macro DISPATCH_PERF_EN adds perf_issued/perf_stalled counters.
//
// Fetch handshake (ifetch_valid/ifetch_ready):
//   - A transfer happens on a rising edge where both ifetch_valid and
//     ifetch_ready are 1.
//   - ifetch_ready is combinational. It can be 1 while the slot is HELD, but
//     only when the held instruction fires in the same cycle.
//   - The fetcher must keep its offer stable until the transfer happens.
module issue_dispatcher #(
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned OPTYPE_W  = 6,
  parameter int unsigned PAYLOAD_W = 64,
  parameter logic [OPTYPE_W-1:0] LS_LO = 6'd11,
  parameter logic [OPTYPE_W-1:0] LS_HI = 6'd18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 ifetch_valid,
  input  logic [OPTYPE_W-1:0]  ifetch_optype,
  input  logic [PAYLOAD_W-1:0] ifetch_payload,
  output logic                 ifetch_ready,
  input  logic                 rob_clear,
  input  logic [TAG_W-1:0]     ROB_nextTag,
  input  logic                 rob_full,
  input  logic                 rs_full,
  input  logic                 lsb_full,
  output logic                 ROB_enable,
  output logic                 RS_enable,
  output logic                 LSB_enable,
  output logic                 reg_rename_enable,
  output logic [TAG_W-1:0]     issue_rdTag,
  output logic [OPTYPE_W-1:0]  issue_optype,
  output logic [PAYLOAD_W-1:0] issue_payload,
  output logic                 dbg_state
`ifdef DISPATCH_PERF_EN
  ,
  output logic [31:0]          perf_issued,
  output logic [31:0]          perf_stalled
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [OPTYPE_W-1:0]    slot_optype;
  logic [PAYLOAD_W-1:0]   slot_payload;
  logic                   slot_valid;
  logic                   is_ls;
  logic                   target_free;
  logic                   fire;
  logic                   accept;

  assign slot_valid  = (state_q == HELD);
  assign is_ls       = (slot_optype >= LS_LO) && (slot_optype <= LS_HI);
  // Only the full flag of the slot's own class can stall it.
  assign target_free = is_ls ? ~lsb_full : ~rs_full;
  assign fire        = slot_valid & rdy & ~rst & ~rob_clear & ~rob_full & target_free;
  assign accept      = ifetch_valid & ifetch_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Clear takes priority over both accept and fire.
  always_comb begin
    state_d = state_q;
    if (rdy) begin
      if (rob_clear) begin
        state_d = EMPTY;
      end else if (accept) begin
        state_d = HELD;
      end else if (fire) begin
        state_d = EMPTY;
      end
    end
  end

  // The slot data only changes on accept or reset, so it is stable while HELD.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_optype  <= '0;
      slot_payload <= '0;
    end else if (accept) begin
      slot_optype  <= ifetch_optype;
      slot_payload <= ifetch_payload;
    end
  end

  always_comb begin
    ifetch_ready      = rdy & ~rst & ~rob_clear & (~slot_valid | fire);
    ROB_enable        = fire;
    reg_rename_enable = fire;
    LSB_enable        = fire & is_ls;
    RS_enable         = fire & ~is_ls;
    issue_rdTag       = fire ? ROB_nextTag : '0;
    issue_optype      = rst ? '0 : slot_optype;
    issue_payload     = rst ? '0 : slot_payload;
    dbg_state         = ~rst & state_q;
  end

`ifdef DISPATCH_PERF_EN
  logic [31:0] issued_q;
  logic [31:0] stalled_q;
  logic        stall;

  assign stall = slot_valid & rdy & ~rob_clear & ~fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      issued_q  <= '0;
      stalled_q <= '0;
    end else begin
      if (fire) begin
        issued_q <= issued_q + 32'd1;
      end
      if (stall) begin
        stalled_q <= stalled_q + 32'd1;
      end
    end
  end

  assign perf_issued  = rst ? '0 : issued_q;
  assign perf_stalled = rst ? '0 : stalled_q;
`endif

endmodule

// File: tb/tb_issue_dispatcher.sv
// Directed bench for issue_dispatcher: routing, backpressure, clear, rdy freeze, reset.
// Compile with DISPATCH_PERF_EN defined to also check the perf counters.
module tb_issue_dispatcher;

  localparam int TAG_W     = 4;
  localparam int OPTYPE_W  = 6;
  localparam int PAYLOAD_W = 64;

  localparam logic [OPTYPE_W-1:0] OP_ADD = 6'd1;
  localparam logic [OPTYPE_W-1:0] OP_LB  = 6'd11;
  localparam logic [OPTYPE_W-1:0] OP_LW  = 6'd13;
  localparam logic [OPTYPE_W-1:0] OP_SW  = 6'd18;
  localparam logic [OPTYPE_W-1:0] OP_X19 = 6'd19;

  // strobe vector order: {ROB, RS, LSB, rename}
  localparam logic [3:0] S_NONE = 4'b0000;
  localparam logic [3:0] S_RS   = 4'b1101;
  localparam logic [3:0] S_LSB  = 4'b1011;

  logic                 clk;
  logic                 rst;
  logic                 rdy;
  logic                 ifetch_valid;
  logic [OPTYPE_W-1:0]  ifetch_optype;
  logic [PAYLOAD_W-1:0] ifetch_payload;
  logic                 ifetch_ready;
  logic                 rob_clear;
  logic [TAG_W-1:0]     ROB_nextTag;
  logic                 rob_full;
  logic                 rs_full;
  logic                 lsb_full;
  logic                 ROB_enable;
  logic                 RS_enable;
  logic                 LSB_enable;
  logic                 reg_rename_enable;
  logic [TAG_W-1:0]     issue_rdTag;
  logic [OPTYPE_W-1:0]  issue_optype;
  logic [PAYLOAD_W-1:0] issue_payload;
  logic                 dbg_state;
`ifdef DISPATCH_PERF_EN
  logic [31:0]          perf_issued;
  logic [31:0]          perf_stalled;
`endif

  logic [3:0] strobes;
  assign strobes = {ROB_enable, RS_enable, LSB_enable, reg_rename_enable};

  int n_cmp;
  int n_err;

  issue_dispatcher #(
    .TAG_W(TAG_W), .OPTYPE_W(OPTYPE_W), .PAYLOAD_W(PAYLOAD_W),
    .LS_LO(6'd11), .LS_HI(6'd18)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .ifetch_valid(ifetch_valid), .ifetch_optype(ifetch_optype),
    .ifetch_payload(ifetch_payload), .ifetch_ready(ifetch_ready),
    .rob_clear(rob_clear), .ROB_nextTag(ROB_nextTag),
    .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
    .ROB_enable(ROB_enable), .RS_enable(RS_enable), .LSB_enable(LSB_enable),
    .reg_rename_enable(reg_rename_enable), .issue_rdTag(issue_rdTag),
    .issue_optype(issue_optype), .issue_payload(issue_payload),
    .dbg_state(dbg_state)
`ifdef DISPATCH_PERF_EN
    ,
    .perf_issued(perf_issued), .perf_stalled(perf_stalled)
`endif
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic offer(input logic [OPTYPE_W-1:0] op, input logic [PAYLOAD_W-1:0] pl);
    ifetch_valid   = 1'b1;
    ifetch_optype  = op;
    ifetch_payload = pl;
  endtask

  task automatic idle_fetch();
    ifetch_valid   = 1'b0;
    ifetch_optype  = '0;
    ifetch_payload = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; rob_clear = 1'b0;
    rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
    ROB_nextTag = 4'd7;
    offer(OP_ADD, 64'hDEAD);
    settle();
    n_cmp++; if (ifetch_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %0b want 0", ifetch_ready); end
    n_cmp++; if (strobes !== S_NONE) begin n_err++; $display("FAIL reset_strobes: got %b want %b", strobes, S_NONE); end
    step();
    n_cmp++; if (issue_payload !== 64'h0) begin n_err++; $display("FAIL reset_payload: got %0h want 0", issue_payload); end
    n_cmp++; if (issue_optype !== 6'd0) begin n_err++; $display("FAIL reset_optype: got %0d want 0", issue_optype); end
    n_cmp++; if (dbg_state !== 1'b0) begin n_err++; $display("FAIL reset_state: got %0b want 0", dbg_state); end
    idle_fetch();
    rst = 1'b0;
    settle();
    n_cmp++; if (ifetch_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready: got %0b want 1", ifetch_ready); end
  endtask

  task automatic test_basic_issue();
    ROB_nextTag = 4'd5;
    offer(OP_ADD, 64'h1111_0000_0000_0001);
    settle();
    n_cmp++; if (strobes !== S_NONE) begin n_err++; $display("FAIL basic_pre_strobes: got %b want %b", strobes, S_NONE); end
    step();
    idle_fetch();
    settle();
    n_cmp++; if (strobes !== S_RS) begin n_err++; $display("FAIL basic_strobes: got %b want %b", strobes, S_RS); end
    n_cmp++; if (issue_rdTag !== 4'd5) begin n_err++; $display("FAIL basic_tag: got %0d want 5", issue_rdTag); end
    n_cmp++; if (issue_payload !== 64'h1111_0000_0000_0001) begin n_err++; $display("FAIL basic_payload: got %0h want 1111000000000001", issue_payload); end
    n_cmp++; if (issue_optype !== OP_ADD) begin n_err++; $display("FAIL basic_optype: got %0d want 1", issue_optype); end
    step();
    n_cmp++; if (strobes !== S_NONE) begin n_err++; $display("FAIL basic_after_strobes: got %b want %b", strobes, S_NONE); end
    n_cmp++; if (issue_rdTag !== 4'd0) begin n_err++; $display("FAIL basic_after_tag: got %0d want 0", issue_rdTag); end
  endtask

  task automatic test_back_to_back();
    logic [OPTYPE_W-1:0] ops[4];
    logic [3:0]          exp_s[4];
    ops[0] = OP_LW; ops[1] = OP_ADD; ops[2] = OP_SW; ops[3] = '0;
    exp_s[0] = S_NONE; exp_s[1] = S_LSB; exp_s[2] = S_RS; exp_s[3] = S_LSB;
    for (int i = 0; i < 4; i++) begin
      ROB_nextTag = 4'(i + 8);
      if (i < 3) offer(ops[i], 64'(i + 100)); else idle_fetch();
      settle();
      n_cmp++; if (strobes !== exp_s[i]) begin n_err++; $display("FAIL b2b_strobes[%0d]: got %b want %b", i, strobes, exp_s[i]); end
      n_cmp++; if (ifetch_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d]: got %0b want 1", i, ifetch_ready); end
      if (i > 0) begin
        n_cmp++; if (issue_rdTag !== 4'(i + 8)) begin n_err++; $display("FAIL b2b_tag[%0d]: got %0d want %0d", i, issue_rdTag, i + 8); end
        n_cmp++; if (issue_payload !== 64'(i + 99)) begin n_err++; $display("FAIL b2b_payload[%0d]: got %0d want %0d", i, issue_payload, i + 99); end
      end
      step();
    end
    n_cmp++; if (dbg_state !== 1'b0) begin n_err++; $display("FAIL b2b_drained: got %0b want 0", dbg_state); end
  endtask

  task automatic test_lsb_stall();
    apply_reset();
    offer(OP_SW, 64'hABCD_0000_1234_5678);
    step();
    lsb_full = 1'b1;
    offer(OP_ADD, 64'h2222);
    for (int i = 0; i < 4; i++) begin
      settle();
      n_cmp++; if (strobes !== S_NONE) begin n_err++; $display("FAIL stall_strobes[%0d]: got %b want %b", i, strobes, S_NONE); end
      n_cmp++; if (ifetch_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready[%0d]: got %0b want 0", i, ifetch_ready); end
      n_cmp++; if (issue_payload !== 64'hABCD_0000_1234_5678) begin n_err++; $display("FAIL stall_payload[%0d]: got %0h want abcd000012345678", i, issue_payload); end
      step();
    end
    lsb_full = 1'b0;
    ROB_nextTag = 4'd3;
    settle();
    n_cmp++; if (strobes !== S_LSB) begin n_err++; $display("FAIL stall_release: got %b want %b", strobes, S_LSB); end
    n_cmp++; if (issue_rdTag !== 4'd3) begin n_err++; $display("FAIL stall_release_tag: got %0d want 3", issue_rdTag); end
    n_cmp++; if (issue_payload !== 64'hABCD_0000_1234_5678) begin n_err++; $display("FAIL stall_release_payload: got %0h want abcd000012345678", issue_payload); end
    n_cmp++; if (ifetch_ready !== 1'b1) begin n_err++; $display("FAIL stall_release_ready: got %0b want 1", ifetch_ready); end
`ifdef DISPATCH_PERF_EN
    n_cmp++; if (perf_stalled !== 32'd4) begin n_err++; $display("FAIL perf_stalled: got %0d want 4", perf_stalled); end
`endif
    step();
`ifdef DISPATCH_PERF_EN
    n_cmp++; if (perf_issued !== 32'd1) begin n_err++; $display("FAIL perf_issued: got %0d want 1", perf_issued); end
    n_cmp++; if (perf_stalled !== 32'd4) begin n_err++; $display("FAIL perf_stalled_after: got %0d want 4", perf_stalled); end
`endif
    n_cmp++; if (issue_payload !== 64'h2222) begin n_err++; $display("FAIL stall_next_loaded: got %0h want 2222", issue_payload); end
  endtask

  task automatic test_wrong_class_full();
    // Slot holds ADD from the previous scenario.
    lsb_full = 1'b1;
    rs_full  = 1'b0;
    offer(OP_LW, 64'h3333);
    settle();
    n_cmp++; if (strobes !== S_RS) begin n_err++; $display("FAIL wrongclass_strobes: got %b want %b", strobes, S_RS); end
    n_cmp++; if (ifetch_ready !== 1'b1) begin n_err++; $display("FAIL wrongclass_ready: got %0b want 1", ifetch_ready); end
    step();
    lsb_full = 1'b0;
    rob_full = 1'b1;
    offer(OP_ADD, 64'h4444);
    settle();
    n_cmp++; if (strobes !== S_NONE) begin n_err++; $display("FAIL robfull_ls: got %b want %b", strobes, S_NONE); end
    n_cmp++; if (ifetch_ready !== 1'b0) begin n_err++; $display("FAIL robfull_ls_ready: got %0b want 0", ifetch_ready); end
    step();
    rob_full = 1'b0;
    settle();
    n_cmp++; if (strobes !== S_LSB) begin n_err++; $display("FAIL robfull_ls_release: got %b want %b", strobes, S_LSB); end
    step();
    rob_full = 1'b1;
    idle_fetch();
    settle();
    n_cmp++; if (strobes !== S_NONE) begin n_err++; $display("FAIL robfull_rs: got %b want %b", strobes, S_NONE); end
    step();
    rob_full = 1'b0;
    settle();
    n_cmp++; if (strobes !== S_RS) begin n_err++; $display("FAIL robfull_rs_release: got %b want %b", strobes, S_RS); end
    n_cmp++; if (issue_payload !== 64'h4444) begin n_err++; $display("FAIL robfull_rs_payload: got %0h want 4444", issue_payload); end
    step();
  endtask

  task automatic test_range_edges();
    // LB is the lowest LS optype; 19 sits just above SW and goes to the RS.
    offer(OP_LB, 64'h5);
    step();
    offer(OP_X19, 64'h6);
    settle();
    n_cmp++; if (strobes !== S_LSB) begin n_err++; $display("FAIL edge_lb: got %b want %b", strobes, S_LSB); end
    step();
    idle_fetch();
    settle();
    n_cmp++; if (strobes !== S_RS) begin n_err++; $display("FAIL edge_op19: got %b want %b", strobes, S_RS); end
    step();
  endtask

  task automatic test_clear();
    offer(OP_ADD, 64'h7777);
    step();
    rs_full = 1'b1;
    idle_fetch();
    step();
    rob_clear = 1'b1;
    offer(OP_LW, 64'h8888);
    settle();
    n_cmp++; if (strobes !== S_NONE) begin n_err++; $display("FAIL clear_strobes: got %b want %b", strobes, S_NONE); end
    n_cmp++; if (ifetch_ready !== 1'b0) begin n_err++; $display("FAIL clear_ready: got %0b want 0", ifetch_ready); end
    step();
    rob_clear = 1'b0;
    rs_full   = 1'b0;
    idle_fetch();
    settle();
    n_cmp++; if (dbg_state !== 1'b0) begin n_err++; $display("FAIL clear_empty: got %0b want 0", dbg_state); end
    n_cmp++; if (strobes !== S_NONE) begin n_err++; $display("FAIL clear_after_strobes: got %b want %b", strobes, S_NONE); end
    n_cmp++; if (ifetch_ready !== 1'b1) begin n_err++; $display("FAIL clear_after_ready: got %0b want 1", ifetch_ready); end
    n_cmp++; if (issue_payload !== 64'h7777) begin n_err++; $display("FAIL clear_not_accepted: got %0h want 7777", issue_payload); end
  endtask

  task automatic test_rdy_freeze();
    offer(OP_SW, 64'h9999_AAAA);
    step();
    rdy = 1'b0;
    offer(OP_ADD, 64'hBBBB);
    for (int i = 0; i < 3; i++) begin
      settle();
      n_cmp++; if (strobes !== S_NONE) begin n_err++; $display("FAIL rdy_strobes[%0d]: got %b want %b", i, strobes, S_NONE); end
      n_cmp++; if (ifetch_ready !== 1'b0) begin n_err++; $display("FAIL rdy_ready[%0d]: got %0b want 0", i, ifetch_ready); end
      n_cmp++; if (issue_payload !== 64'h9999_AAAA) begin n_err++; $display("FAIL rdy_payload[%0d]: got %0h want 9999aaaa", i, issue_payload); end
      n_cmp++; if (issue_optype !== OP_SW) begin n_err++; $display("FAIL rdy_optype[%0d]: got %0d want 18", i, issue_optype); end
      step();
    end
    rdy = 1'b1;
    idle_fetch();
    ROB_nextTag = 4'd12;
    settle();
    n_cmp++; if (strobes !== S_LSB) begin n_err++; $display("FAIL rdy_release: got %b want %b", strobes, S_LSB); end
    n_cmp++; if (issue_rdTag !== 4'd12) begin n_err++; $display("FAIL rdy_release_tag: got %0d want 12", issue_rdTag); end
    step();
  endtask

  task automatic test_reset_mid_hold();
    offer(OP_ADD, 64'hCCCC);
    step();
    idle_fetch();
    rst = 1'b1;
    settle();
    n_cmp++; if (strobes !== S_NONE) begin n_err++; $display("FAIL rsthold_strobes: got %b want %b", strobes, S_NONE); end
    n_cmp++; if (ifetch_ready !== 1'b0) begin n_err++; $display("FAIL rsthold_ready: got %0b want 0", ifetch_ready); end
    step();
    rst = 1'b0;
    settle();
    n_cmp++; if (dbg_state !== 1'b0) begin n_err++; $display("FAIL rsthold_empty: got %0b want 0", dbg_state); end
    n_cmp++; if (strobes !== S_NONE) begin n_err++; $display("FAIL rsthold_after: got %b want %b", strobes, S_NONE); end
    n_cmp++; if (issue_payload !== 64'h0) begin n_err++; $display("FAIL rsthold_payload: got %0h want 0", issue_payload); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; rdy = 1'b1; rob_clear = 1'b0;
    rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
    ROB_nextTag = '0;
    idle_fetch();
    step();
    test_reset();
    test_basic_issue();
    test_back_to_back();
    test_lsb_stall();
    test_wrong_class_full();
    test_range_edges();
    test_clear();
    test_rdy_freeze();
    test_reset_mid_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
